regfile_write_arbiter: RTL and testbench

- Initiator side of the register file write port: the only driver of regwrite/writereg/writedata in the pipelined RISC-V core.
- Merges two result sources into the single write port:
  - the in-order pipeline writeback stage, which has priority;
  - a long-latency auxiliary unit (divider/load-miss return), buffered through a small FIFO.
- Publishes a pending-destination mask for the hazard unit and a stall request that bounds auxiliary starvation.

---
 rtl/regfile_write_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Sole driver of the register file write port. Merges two result sources:
//   - the in-order pipeline writeback stage (priority source), and
//   - a long-latency auxiliary unit, buffered through a DEPTH-entry FIFO.
// A pending-destination mask is published for the hazard unit. A starvation
// counter forces one FIFO pop (wb_stall) when the FIFO head has been blocked
// by pipeline writes for STARVE_LIMIT consecutive cycles.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   wb_valid/wb_rd/wb_data   pipeline writeback request
//   aux_valid/aux_rd/aux_data, aux_ready   auxiliary result handshake
//   wb_stall                 pipeline must hold its writeback this cycle
//   regwrite/writereg/writedata   registered register file write port
//   pend_mask                bit r set while any FIFO entry targets x_r
//   fifo_count               occupied FIFO entries
//   err_waw                  sticky: pipeline wrote a register pending in FIFO
// -----------------------------------------------------------------------------

// Structural invariants of the arbiter outputs, kept apart from the design logic.
module regfile_write_arbiter_checker #(
  parameter int DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  input logic                      regwrite,
  input logic [4:0]                writereg,
  input logic                      wb_stall,
  input logic                      aux_ready,
  input logic [$clog2(DEPTH):0]    fifo_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_COUNT = {CW{1'b0}};

  a_no_x0_write: assert property (@(posedge clk) disable iff (rst)
    regwrite |-> (writereg != 5'd0));
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= FULL_COUNT);
  a_stall_nonempty: assert property (@(posedge clk) disable iff (rst)
    wb_stall |-> (fifo_count != ZERO_COUNT));
  a_stall_single: assert property (@(posedge clk) disable iff (rst)
    wb_stall |=> !wb_stall);
  a_ready_matches_count: assert property (@(posedge clk) disable iff (rst)
    aux_ready == (fifo_count != FULL_COUNT));
endmodule

module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_rd,
  input  logic [31:0]              wb_data,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [4:0]               aux_rd,
  input  logic [31:0]              aux_data,
  output logic                     wb_stall,
  output logic                     regwrite,
  output logic [4:0]               writereg,
  output logic [31:0]              writedata,
  output logic [31:0]              pend_mask,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_waw
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Source chosen for the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_AUX  = 2'd2
  } src_e;

  // One-hot decode of a destination register number.
  function automatic logic [31:0] rd_decode(input logic [4:0] rd);
    rd_decode = 32'h0000_0001 << rd;
  endfunction

  // FIFO storage and pointers
  logic [4:0]    rd_mem_r   [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [SW-1:0] starve_r;

  // Registered write port and sticky error
  logic          regwrite_r;
  logic [4:0]    writereg_r;
  logic [31:0]   writedata_r;
  logic          err_waw_r;

  // Combinational control
  logic          empty_s;
  logic          full_s;
  logic          stall_s;
  logic          wb_req_s;
  logic          push_store_s;
  logic          pop_s;
  logic          sel_wb_s;
  logic [31:0]   pend_mask_s;
  src_e          src_s;

  assign empty_s  = (count_r == {CW{1'b0}});
  assign full_s   = (count_r == FULL_COUNT);
  assign stall_s  = (starve_r == STARVE_MAX) && !empty_s;
  // A pipeline write to x0 is not a real request.
  assign wb_req_s = wb_valid && (wb_rd != 5'd0);
  // Full FIFO refuses even when a pop happens this cycle; x0 results are
  // acknowledged but dropped.
  assign push_store_s = aux_valid && !full_s && (aux_rd != 5'd0);

  // Priority selection: forced pop, then pipeline, then FIFO head.
  always_comb begin
    src_s = SRC_NONE;
    if (stall_s) begin
      src_s = SRC_AUX;
    end else if (wb_req_s) begin
      src_s = SRC_WB;
    end else if (!empty_s) begin
      src_s = SRC_AUX;
    end else begin
      src_s = SRC_NONE;
    end
  end

  assign pop_s    = (src_s == SRC_AUX);
  assign sel_wb_s = (src_s == SRC_WB);

  // Pending-destination mask: OR of decodes of the occupied FIFO slots.
  always_comb begin
    pend_mask_s = 32'h0000_0000;
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i is occupied when its distance from the read pointer is below count.
      if ({1'b0, AW'(AW'(i) - rd_ptr_r)} < count_r) begin
        pend_mask_s = pend_mask_s | rd_decode(rd_mem_r[i]);
      end else begin
        pend_mask_s = pend_mask_s;
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem_r[i]   <= 5'd0;
        data_mem_r[i] <= 32'h0000_0000;
      end
    end else begin
      if (push_store_s) begin
        rd_mem_r[wr_ptr_r]   <= aux_rd;
        data_mem_r[wr_ptr_r] <= aux_data;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_store_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter: counts pipeline wins over a waiting FIFO head.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_r <= {SW{1'b0}};
    end else if (pop_s || empty_s) begin
      starve_r <= {SW{1'b0}};
    end else if (sel_wb_s && (starve_r != STARVE_MAX)) begin
      starve_r <= starve_r + STARVE_ONE;
    end else begin
      starve_r <= starve_r;
    end
  end

  // Registered write port; address/data hold when nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_r  <= 1'b0;
      writereg_r  <= 5'd0;
      writedata_r <= 32'h0000_0000;
    end else begin
      case (src_s)
        SRC_WB: begin
          regwrite_r  <= 1'b1;
          writereg_r  <= wb_rd;
          writedata_r <= wb_data;
        end
        SRC_AUX: begin
          regwrite_r  <= 1'b1;
          writereg_r  <= rd_mem_r[rd_ptr_r];
          writedata_r <= data_mem_r[rd_ptr_r];
        end
        default: begin
          regwrite_r  <= 1'b0;
          writereg_r  <= writereg_r;
          writedata_r <= writedata_r;
        end
      endcase
    end
  end

  // Sticky WAW flag: pipeline overtook a buffered write to the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_waw_r <= 1'b0;
    end else if (sel_wb_s && pend_mask_s[wb_rd]) begin
      err_waw_r <= 1'b1;
    end else begin
      err_waw_r <= err_waw_r;
    end
  end

  assign aux_ready  = !full_s;
  assign wb_stall   = stall_s;
  assign pend_mask  = pend_mask_s;
  assign fifo_count = count_r;
  assign regwrite   = regwrite_r;
  assign writereg   = writereg_r;
  assign writedata  = writedata_r;
  assign err_waw    = err_waw_r;

  regfile_write_arbiter_checker #(
    .DEPTH (DEPTH)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .regwrite   (regwrite_r),
    .writereg   (writereg_r),
    .wb_stall   (stall_s),
    .aux_ready  (aux_ready),
    .fifo_count (count_r)
  );
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter. A behavioural model (queue
// FIFO, starvation counter, sticky WAW flag) predicts every cycle; selected
// writes are pushed to a scoreboard when stimulus is driven and popped when
// the registered write port is sampled. A hand-derived vector table and a few
// directed sequences add fixed expectations on top.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_rd;
  logic [31:0] aux_data;
  logic        wb_stall;
  logic        regwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_count;
  logic        err_waw;

  regfile_write_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .aux_valid  (aux_valid),
    .aux_ready  (aux_ready),
    .aux_rd     (aux_rd),
    .aux_data   (aux_data),
    .wb_stall   (wb_stall),
    .regwrite   (regwrite),
    .writereg   (writereg),
    .writedata  (writedata),
    .pend_mask  (pend_mask),
    .fifo_count (fifo_count),
    .err_waw    (err_waw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic [2:0]  e_cnt;
    logic [31:0] e_pend;
    logic        e_rw;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_err;
  } vec_t;

  int          n_cmp;
  int          n_err;
  wr_t         mq[$];
  wr_t         sb[$];
  int          m_starve;
  logic        m_err;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic        obs_stall;
  logic        obs_ready;
  logic [2:0]  obs_count;
  logic [31:0] obs_pend;
  vec_t        vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus with model prediction and scoreboard checking.
  task automatic cycle(input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
    int          sz;
    logic        full_e;
    logic        stall_e;
    logic        wb_sel;
    logic        pop_sel;
    logic [31:0] pm_e;
    wr_t         ent;
    wb_valid  = wbv;
    wb_rd     = wbrd;
    wb_data   = wbd;
    aux_valid = av;
    aux_rd    = ard;
    aux_data  = ad;
    #1;
    sz      = mq.size();
    full_e  = (sz == DEPTH);
    stall_e = (m_starve == STARVE_LIMIT) && (sz != 0);
    pm_e    = 32'h0;
    foreach (mq[i]) pm_e[mq[i].rd] = 1'b1;
    obs_stall = wb_stall;
    obs_ready = aux_ready;
    obs_count = fifo_count;
    obs_pend  = pend_mask;
    chk("aux_ready", 32'(aux_ready), 32'(!full_e));
    chk("wb_stall", 32'(wb_stall), 32'(stall_e));
    chk("fifo_count", 32'(fifo_count), 32'(sz));
    chk("pend_mask", pend_mask, pm_e);
    wb_sel  = !stall_e && wbv && (wbrd != 5'd0);
    pop_sel = !wb_sel && (sz != 0);
    if (wb_sel) begin
      foreach (mq[i]) if (mq[i].rd == wbrd) m_err = 1'b1;
      sb.push_back('{wbrd, wbd});
    end
    if (pop_sel) sb.push_back(mq.pop_front());
    if (pop_sel || sz == 0) m_starve = 0;
    else if (wb_sel && m_starve < STARVE_LIMIT) m_starve++;
    if (av && !full_e && ard != 5'd0) mq.push_back('{ard, ad});
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      ent = sb.pop_front();
      chk("regwrite", 32'(regwrite), 32'd1);
      chk("writereg", 32'(writereg), 32'(ent.rd));
      chk("writedata", writedata, ent.data);
      m_wreg  = ent.rd;
      m_wdata = ent.data;
    end else begin
      chk("regwrite", 32'(regwrite), 32'd0);
      chk("writereg_hold", 32'(writereg), 32'(m_wreg));
      chk("writedata_hold", writedata, m_wdata);
    end
    chk("err_waw", 32'(err_waw), 32'(m_err));
  endtask

  // Hold reset for n edges with traffic offered, then check the reset state.
  task automatic do_reset(input int n);
    rst       = 1'b1;
    wb_valid  = 1'b1;
    wb_rd     = 5'd17;
    wb_data   = 32'hFEED_F00D;
    aux_valid = 1'b1;
    aux_rd    = 5'd2;
    aux_data  = 32'h2222_2222;
    repeat (n) @(posedge clk);
    #1;
    mq.delete();
    sb.delete();
    m_starve = 0;
    m_err    = 1'b0;
    m_wreg   = 5'd0;
    m_wdata  = 32'h0;
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_pend_mask", pend_mask, 32'h0);
    chk("rst_regwrite", 32'(regwrite), 32'd0);
    chk("rst_writereg", 32'(writereg), 32'd0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_aux_ready", 32'(aux_ready), 32'd1);
    chk("rst_wb_stall", 32'(wb_stall), 32'd0);
    chk("rst_err_waw", 32'(err_waw), 32'd0);
    rst       = 1'b0;
    wb_valid  = 1'b0;
    aux_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall_at;
    int stall_hits;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    aux_valid = 1'b0; aux_rd = 5'd0; aux_data = 32'h0;
    m_starve = 0; m_err = 1'b0; m_wreg = 5'd0; m_wdata = 32'h0;

    //          wbv   wbrd   wbd            av    ard    ad             cnt   pend         rw    wr     wd             err
    vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        3'd0, 32'h0,       1'b1, 5'd5,  32'hDEADBEEF, 1'b0};
    vt[1]  = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd0,  32'h0,        3'd0, 32'h0,       1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h12345678, 3'd0, 32'h0,       1'b0, 5'd5,  32'hDEADBEEF, 1'b0};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        3'd1, 32'h80,      1'b1, 5'd7,  32'h12345678, 1'b0};
    vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        3'd0, 32'h0,       1'b0, 5'd7,  32'h12345678, 1'b0};
    vt[5]  = '{1'b1, 5'd10, 32'hA5A5A5A5, 1'b1, 5'd3,  32'h33333333, 3'd0, 32'h0,       1'b1, 5'd10, 32'hA5A5A5A5, 1'b0};
    vt[6]  = '{1'b1, 5'd3,  32'h0BAD0BAD, 1'b0, 5'd0,  32'h0,        3'd1, 32'h8,       1'b1, 5'd3,  32'h0BAD0BAD, 1'b1};
    vt[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        3'd1, 32'h8,       1'b1, 5'd3,  32'h33333333, 1'b1};
    vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 3'd0, 32'h0,       1'b0, 5'd3,  32'h33333333, 1'b1};
    vt[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        3'd0, 32'h0,       1'b0, 5'd3,  32'h33333333, 1'b1};
    vt[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        3'd0, 32'h0,       1'b0, 5'd3,  32'h33333333, 1'b1};

    do_reset(2);

    // Table: pipeline only, x0 filter, aux latency, WAW and aux x0 drop.
    for (int k = 0; k < 11; k++) begin
      cycle(vt[k].wbv, vt[k].wbrd, vt[k].wbd, vt[k].av, vt[k].ard, vt[k].ad);
      chk($sformatf("vec%0d_count", k), 32'(obs_count), 32'(vt[k].e_cnt));
      chk($sformatf("vec%0d_pend", k), obs_pend, vt[k].e_pend);
      chk($sformatf("vec%0d_regwrite", k), 32'(regwrite), 32'(vt[k].e_rw));
      chk($sformatf("vec%0d_writereg", k), 32'(writereg), 32'(vt[k].e_wr));
      chk($sformatf("vec%0d_writedata", k), writedata, vt[k].e_wd);
      chk($sformatf("vec%0d_err", k), 32'(err_waw), 32'(vt[k].e_err));
    end

    // Fill under continuous pipeline writes, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 5'(20 + i), 32'hB000_0000 + 32'(i), 1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i + 1));
    end
    cycle(1'b1, 5'd24, 32'hB000_0004, 1'b1, 5'd5, 32'hA000_0005);
    chk("full_ready", 32'(obs_ready), 32'd0);
    chk("full_count", 32'(obs_count), 32'd4);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      chk($sformatf("order%0d_rd", i), 32'(writereg), 32'(i + 1));
      chk($sformatf("order%0d_data", i), writedata, 32'hA000_0000 + 32'(i + 1));
    end
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("drained_regwrite", 32'(regwrite), 32'd0);

    // Starvation: rd=9 waits behind pipeline writes every cycle.
    cycle(1'b1, 5'd11, 32'hC000_0000, 1'b1, 5'd9, 32'h9999_0009);
    stall_at   = 0;
    stall_hits = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle(1'b1, 5'd12, 32'hC000_0000 + 32'(c), 1'b0, 5'd0, 32'h0);
      if (obs_stall) begin
        stall_hits++;
        if (stall_at == 0) begin
          stall_at = c;
          chk("starve_pop_rd", 32'(writereg), 32'd9);
          chk("starve_pop_data", writedata, 32'h9999_0009);
        end
      end
    end
    chk("starve_cycle", 32'(stall_at), 32'd9);
    chk("starve_hits", 32'(stall_hits), 32'd1);

    // Reset mid-operation with three buffered entries and a sticky error.
    cycle(1'b1, 5'd13, 32'hD000_0001, 1'b1, 5'd4, 32'hE000_0004);
    cycle(1'b1, 5'd4,  32'hD000_0002, 1'b1, 5'd6, 32'hE000_0006);
    cycle(1'b1, 5'd15, 32'hD000_0003, 1'b1, 5'd8, 32'hE000_0008);
    chk("pre_reset_count", 32'(fifo_count), 32'd3);
    chk("pre_reset_err", 32'(err_waw), 32'd1);
    do_reset(2);

    // Randomised traffic against the model.
    for (int r = 0; r < 300; r++) begin
      cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom());
    end
    for (int r = 0; r < DEPTH + 2; r++) begin
      cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    end
    chk("final_count", 32'(fifo_count), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
